// File: rtl/dmem_sb_responder_if.sv
// Core-to-data-memory M-stage bus: address, store data, store strobe and load data.
// The core drives the master end; the store-buffer responder is the slave end.
interface dmem_sb_responder_if;
   logic [31:0] ALUOutM;
   logic [31:0] WriteDataM;
   logic        MemWriteM;
   logic [31:0] ReadDataM;

   modport master (
      output ALUOutM,
      output WriteDataM,
      output MemWriteM,
      input  ReadDataM
   );

   modport slave (
      input  ALUOutM,
      input  WriteDataM,
      input  MemWriteM,
      output ReadDataM
   );
endinterface

// File: rtl/dmem_sb_responder.sv
// Data-memory responder: DEPTH-entry store buffer draining into a word RAM, with same-cycle
// forwarding on loads. Optional macro DMEM_CYCLE_CNT_EN maps a cycle counter at 0xFFFF_FFFC.
module dmem_sb_responder #(
   parameter int ADDR_BITS = 10,
   parameter int DEPTH     = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   dmem_sb_responder_if.slave       bus,
   input  logic                     RamBusy,
   output logic                     SbEmpty,
   output logic                     SbFull,
   output logic [$clog2(DEPTH):0]   SbCount,
   output logic [15:0]              ForcedDrainCnt
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   logic [ADDR_BITS-1:0] widx;
   logic                 unused_addr_bits;

   assign widx             = bus.ALUOutM[ADDR_BITS+1:2];
   assign unused_addr_bits = ^{bus.ALUOutM[31:ADDR_BITS+2], bus.ALUOutM[1:0]};

   // Buffer storage and RAM carry no reset; only pointers and counters do.
   logic [ADDR_BITS-1:0] idx_q [DEPTH];
   logic [31:0]          dat_q [DEPTH];
   logic [31:0]          ram_q [2**ADDR_BITS];

   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] cnt_q,  cnt_d;
   logic [15:0]   fdc_q,  fdc_d;

   logic is_cyc;
   logic push;
   logic drain;
   logic empty;
   logic full;

   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == CW'(DEPTH));

`ifdef DMEM_CYCLE_CNT_EN
   logic [31:0] cyc_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cyc_q <= '0;
      else        cyc_q <= cyc_q + 32'd1;
   end

   assign is_cyc = (bus.ALUOutM == 32'hFFFF_FFFC);
`else
   assign is_cyc = 1'b0;
`endif

   assign push = bus.MemWriteM & ~is_cyc;

   // A full buffer facing a new store must make room even if the RAM port is claimed.
   assign drain = ~empty & (~RamBusy | (full & push));

   always_comb begin
      head_d = drain ? head_q + PW'(1) : head_q;
      tail_d = push  ? tail_q + PW'(1) : tail_q;
      fdc_d  = (drain & RamBusy) ? sat_inc16(fdc_q) : fdc_q;
      unique case ({push, drain})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
         fdc_q  <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
         fdc_q  <= fdc_d;
      end
   end

   // When full, tail equals head: the new entry overwrites the slot the RAM is taking this edge.
   always_ff @(posedge clk) begin
      if (push) begin
         idx_q[tail_q] <= widx;
         dat_q[tail_q] <= bus.WriteDataM;
      end
   end

   always_ff @(posedge clk) begin
      if (drain) ram_q[idx_q[head_q]] <= dat_q[head_q];
   end

   logic        fwd_hit;
   logic [31:0] fwd_dat;
   logic [31:0] rd_data;

   // Walk oldest to youngest so the last match found is the youngest one.
   always_comb begin
      logic [PW-1:0] pos;
      pos     = head_q;
      fwd_hit = 1'b0;
      fwd_dat = '0;
      for (int k = 0; k < DEPTH; k++) begin
         pos = head_q + k[PW-1:0];
         if ((CW'(k) < cnt_q) && (idx_q[pos] == widx)) begin
            fwd_hit = 1'b1;
            fwd_dat = dat_q[pos];
         end
      end
      rd_data = fwd_hit ? fwd_dat : ram_q[widx];
   end

`ifdef DMEM_CYCLE_CNT_EN
   assign bus.ReadDataM = is_cyc ? cyc_q : rd_data;
`else
   assign bus.ReadDataM = rd_data;
`endif

   assign SbCount        = cnt_q;
   assign SbEmpty        = empty;
   assign SbFull         = full;
   assign ForcedDrainCnt = fdc_q;

   a_no_drop: assert property (@(posedge clk) disable iff (!reset) (push && full) |-> drain);

endmodule

// File: tb/tb_dmem_sb_responder.sv
// Randomized and directed bench for dmem_sb_responder against a queue-based memory model.
// Define DMEM_CYCLE_CNT_EN for both files to exercise the cycle-counter address.
module tb_dmem_sb_responder;
   localparam int AB    = 10;
   localparam int DEPTH = 4;

   logic clk     = 1'b0;
   logic reset   = 1'b0;
   logic RamBusy = 1'b0;
   logic SbEmpty, SbFull;
   logic [$clog2(DEPTH):0] SbCount;
   logic [15:0] ForcedDrainCnt;

   dmem_sb_responder_if bus ();

   dmem_sb_responder #(.ADDR_BITS(AB), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .reset          (reset),
      .bus            (bus),
      .RamBusy        (RamBusy),
      .SbEmpty        (SbEmpty),
      .SbFull         (SbFull),
      .SbCount        (SbCount),
      .ForcedDrainCnt (ForcedDrainCnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AB-1:0] idx;
      logic [31:0]   dat;
   } ent_t;

   ent_t        q [$];
   logic [31:0] mram [int];
   int          fdc_m;
   int unsigned cyc_m;
   int          nvec;
   int          nerr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit is_cyc(input logic [31:0] a);
`ifdef DMEM_CYCLE_CNT_EN
      return a == 32'hFFFF_FFFC;
`else
      return (a != a);
`endif
   endfunction

   // Youngest buffered store wins, then RAM; returns 0 when the value is unknown.
   function automatic bit model_read(input logic [31:0] a, output logic [31:0] d);
      logic [AB-1:0] idx;
      idx = a[AB+1:2];
      d   = '0;
      if (is_cyc(a)) begin
         d = cyc_m;
         return 1'b1;
      end
      for (int i = q.size() - 1; i >= 0; i--) begin
         if (q[i].idx == idx) begin
            d = q[i].dat;
            return 1'b1;
         end
      end
      if (mram.exists(int'(idx))) begin
         d = mram[int'(idx)];
         return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic step(input bit we, input logic [31:0] addr, input logic [31:0] data,
                       input bit busy);
      logic [31:0] exp;
      bit          push, drain;
      ent_t        e;
      bus.MemWriteM  = we;
      bus.ALUOutM    = addr;
      bus.WriteDataM = data;
      RamBusy        = busy;
      #1;
      if (!we && model_read(addr, exp)) chk("read", bus.ReadDataM, exp);
      chk("count", 32'(SbCount), 32'(q.size()));
      chk("empty", 32'(SbEmpty), 32'(q.size() == 0));
      chk("full",  32'(SbFull),  32'(q.size() == DEPTH));
      chk("fdc",   32'(ForcedDrainCnt), 32'(fdc_m));
      push  = we && !is_cyc(addr);
      drain = (q.size() > 0) && (!busy || (q.size() == DEPTH && push));
      @(posedge clk);
      if (drain) begin
         e = q.pop_front();
         mram[int'(e.idx)] = e.dat;
         if (busy && fdc_m < 65535) fdc_m++;
      end
      if (push) begin
         e.idx = addr[AB+1:2];
         e.dat = data;
         q.push_back(e);
      end
      cyc_m++;
      @(negedge clk);
   endtask

   task automatic rd(input logic [31:0] addr, input bit busy);
      step(1'b0, addr, 32'h0, busy);
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data, input bit busy);
      step(1'b1, addr, data, busy);
   endtask

   // Asserts reset between edges, checks outputs respond without a clock, then releases.
   task automatic do_reset();
      bus.MemWriteM = 1'b0;
      #2 reset = 1'b0;
      #1;
      chk("rst_count", 32'(SbCount), 32'd0);
      chk("rst_empty", 32'(SbEmpty), 32'd1);
      chk("rst_full",  32'(SbFull),  32'd0);
      chk("rst_fdc",   32'(ForcedDrainCnt), 32'd0);
      q.delete();
      fdc_m = 0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      cyc_m = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] a;
      nvec = 0;
      nerr = 0;
      fdc_m = 0;
      cyc_m = 0;
      bus.ALUOutM    = '0;
      bus.WriteDataM = '0;
      bus.MemWriteM  = 1'b0;
      @(negedge clk);
      do_reset();

      // Store becomes visible next cycle, then drains.
      wr(32'h100, 32'hDEAD_BEEF, 1'b0);
      chk("t1_cnt1", 32'(SbCount), 32'd1);
      rd(32'h100, 1'b0);
      chk("t1_cnt0", 32'(SbCount), 32'd0);

      // Youngest-entry forwarding while the RAM port is claimed.
      wr(32'h10, 32'd1, 1'b1);
      wr(32'h10, 32'd2, 1'b1);
      wr(32'h14, 32'd3, 1'b1);
      chk("t2_cnt3", 32'(SbCount), 32'd3);
      rd(32'h10, 1'b1);
      rd(32'h14, 1'b1);
      for (int i = 0; i < 3; i++) rd(32'h0, 1'b0);
      chk("t2_empty", 32'(SbEmpty), 32'd1);
      rd(32'h10, 1'b0);
      rd(32'h14, 1'b0);

      // Forced drain when full and another store arrives.
      wr(32'h20, 32'h11, 1'b1);
      wr(32'h24, 32'h22, 1'b1);
      wr(32'h20, 32'h33, 1'b1);
      wr(32'h28, 32'h44, 1'b1);
      chk("t3_full", 32'(SbFull), 32'd1);
      wr(32'h20, 32'h55, 1'b1);
      chk("t3_cnt4", 32'(SbCount), 32'd4);
      chk("t3_fdc1", 32'(ForcedDrainCnt), 32'd1);
      rd(32'h20, 1'b1);
      for (int i = 0; i < 5; i++) rd(32'h0, 1'b0);
      rd(32'h20, 1'b0);
      rd(32'h24, 1'b0);
      rd(32'h28, 1'b0);

      // Wrap-around with toggling busy.
      for (int i = 0; i < 3 * DEPTH; i++) wr(32'h200 + 32'(4 * i), $urandom(), (i % 2) == 1);
      for (int i = 0; i < DEPTH + 2; i++) rd(32'h0, 1'b0);
      for (int i = 0; i < 3 * DEPTH; i++) rd(32'h200 + 32'(4 * i), 1'b0);

      // Random traffic over a small index set with random alias bits.
      for (int i = 0; i < 400; i++) begin
         a = $urandom();
         a[AB+1:2] = AB'($urandom_range(0, 15));
         if ($urandom_range(0, 2) == 0) wr(a, $urandom(), $urandom_range(0, 3) != 0);
         else                           rd(a, $urandom_range(0, 3) != 0);
      end
      for (int i = 0; i < DEPTH + 2; i++) rd(32'h0, 1'b0);
      for (int i = 0; i < 16; i++) begin
         a = $urandom();
         a[AB+1:2] = AB'(i);
         rd(a, 1'b0);
      end

      // Reset with buffered stores discards them; RAM keeps drained data.
      wr(32'h100, 32'hAAAA_0001, 1'b1);
      wr(32'h10,  32'hAAAA_0002, 1'b1);
      wr(32'h14,  32'hAAAA_0003, 1'b1);
      chk("t5_cnt3", 32'(SbCount), 32'd3);
      do_reset();
      rd(32'h100, 1'b0);
      rd(32'h10, 1'b0);
      rd(32'h14, 1'b0);

`ifdef DMEM_CYCLE_CNT_EN
      @(negedge clk);
      do_reset();
      for (int i = 0; i < 10; i++) rd(32'h0, 1'b0);
      bus.ALUOutM   = 32'hFFFF_FFFC;
      bus.MemWriteM = 1'b0;
      #1 chk("t6_cyc10", bus.ReadDataM, 32'd10);
      @(negedge clk);
      cyc_m++;
      wr(32'hFFFF_FFFC, 32'h1234_5678, 1'b1);
      chk("t6_nopush", 32'(SbCount), 32'd0);
      rd(32'hFFFF_FFFC, 1'b1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
